stopwatch_ctrl: RTL and testbench

Stopwatch sequencer for the 7-segment stopwatch display path. Conditions three push-button inputs, runs the start/pause/clear state machine, and generates the 100 Hz time base. Maintains the min/sec/0.01 s binary counters and drives `run` and a one-cycle lap strobe into the display block, which freezes the lap value.

---
 rtl/stopwatch_pkg.sv | 15 +
 rtl/stopwatch_ctrl_button_cond.sv | 88 ++++++++
 rtl/stopwatch_ctrl.sv | 129 ++++++++++++
 tb/tb_stopwatch_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and limits for the stopwatch sequencer.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_PAUSED  = 2'd2
  } state_e;

  localparam int unsigned TIME_W  = 8;
  localparam int unsigned MIL_MAX = 99;
  localparam int unsigned SEC_MAX = 59;
  localparam int unsigned MIN_MAX = 59;

endpackage

// File: rtl/stopwatch_ctrl_button_cond.sv
// Push-button conditioner: 2-flop synchronizer, optional stable-level filter
// (STOPWATCH_DEBOUNCE_EN) and registered rising-edge detector.
module button_cond #(
  parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic evt
);

  logic [1:0] sync_q, sync_d;
  logic       prev_q, prev_d;
  logic       evt_q, evt_d;
  logic       level;

`ifdef STOPWATCH_DEBOUNCE_EN
  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned SETTLE = DEBOUNCE_CYCLES + 4;

  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            filt_q, filt_d;

  // Output follows the input only after it holds a new level long enough.
  always_comb begin
    db_cnt_d = '0;
    filt_d   = filt_q;
    if (sync_q[1] != filt_q) begin
      if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        filt_d = sync_q[1];
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_cnt_q <= '0;
      filt_q   <= 1'b0;
    end else begin
      db_cnt_q <= db_cnt_d;
      filt_q   <= filt_d;
    end
  end

  assign level = filt_q;
`else
  localparam int unsigned SETTLE = 3;

  logic unused_db;
  assign unused_db = ^DEBOUNCE_CYCLES;
  assign level     = sync_q[1];
`endif

  localparam int unsigned ST_W = $clog2(SETTLE + 1);

  // Edges are blanked until the pipeline has flushed, so a button held
  // through reset release never looks like a fresh press.
  logic [ST_W-1:0] settle_q, settle_d;
  logic            settled;

  assign settled = (settle_q == ST_W'(SETTLE));

  always_comb begin
    sync_d   = {sync_q[0], btn};
    prev_d   = level;
    evt_d    = settled & level & ~prev_q;
    settle_d = settled ? settle_q : settle_q + ST_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q   <= '0;
      prev_q   <= 1'b0;
      evt_q    <= 1'b0;
      settle_q <= '0;
    end else begin
      sync_q   <= sync_d;
      prev_q   <= prev_d;
      evt_q    <= evt_d;
      settle_q <= settle_d;
    end
  end

  assign evt = evt_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: start/pause/clear FSM, 100 Hz prescaler and min:sec:mil
// counters. Button debounce is enabled with STOPWATCH_DEBOUNCE_EN.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned CLK_HZ          = 50_000_000,
  parameter int unsigned TICK_HZ         = 100,
  parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
  input  logic              mclk,
  input  logic              reset,
  input  logic              b_start,
  input  logic              b_lap,
  input  logic              b_clear,
  output logic              run,
  output logic              lap_pulse,
  output logic [TIME_W-1:0] min,
  output logic [TIME_W-1:0] sec,
  output logic [TIME_W-1:0] mil,
  output logic              overflow
);

  localparam int unsigned DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned PW  = $clog2(DIV);

  logic start_evt, lap_evt, clear_evt;

  button_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start (
    .clk(mclk), .rst(reset), .btn(b_start), .evt(start_evt)
  );
  button_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lap (
    .clk(mclk), .rst(reset), .btn(b_lap), .evt(lap_evt)
  );
  button_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
    .clk(mclk), .rst(reset), .btn(b_clear), .evt(clear_evt)
  );

  state_e            state_q, state_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic [TIME_W-1:0] min_q, min_d, sec_q, sec_d, mil_q, mil_d;
  logic              run_q, run_d, lap_q, lap_d, ovf_q, ovf_d;
  logic              tick;

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    min_d   = min_q;
    sec_d   = sec_q;
    mil_d   = mil_q;
    lap_d   = 1'b0;
    ovf_d   = 1'b0;
    tick    = (state_q == ST_RUNNING) && (presc_q == PW'(DIV - 1));

    // Clear beats start when paused; start beats lap when running.
    case (state_q)
      ST_IDLE:    if (start_evt) state_d = ST_RUNNING;
      ST_RUNNING: begin
        if (start_evt)    state_d = ST_PAUSED;
        else if (lap_evt) lap_d   = 1'b1;
      end
      ST_PAUSED: begin
        if (clear_evt)      state_d = ST_IDLE;
        else if (start_evt) state_d = ST_RUNNING;
      end
      default:    state_d = ST_IDLE;
    endcase

    if (state_q == ST_RUNNING) presc_d = tick ? '0 : presc_q + PW'(1);

    // All carries resolve in one update.
    if (tick) begin
      if (mil_q == TIME_W'(MIL_MAX)) begin
        mil_d = '0;
        if (sec_q == TIME_W'(SEC_MAX)) begin
          sec_d = '0;
          if (min_q == TIME_W'(MIN_MAX)) begin
            min_d = '0;
            ovf_d = 1'b1;
          end else begin
            min_d = min_q + TIME_W'(1);
          end
        end else begin
          sec_d = sec_q + TIME_W'(1);
        end
      end else begin
        mil_d = mil_q + TIME_W'(1);
      end
    end

    if (state_d == ST_IDLE && state_q != ST_IDLE) begin
      presc_d = '0;
      min_d   = '0;
      sec_d   = '0;
      mil_d   = '0;
    end

    run_d = (state_d == ST_RUNNING);
  end

  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      presc_q <= '0;
      min_q   <= '0;
      sec_q   <= '0;
      mil_q   <= '0;
      run_q   <= 1'b0;
      lap_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      mil_q   <= mil_d;
      run_q   <= run_d;
      lap_q   <= lap_d;
      ovf_q   <= ovf_d;
    end
  end

  assign run       = run_q;
  assign lap_pulse = lap_q;
  assign min       = min_q;
  assign sec       = sec_q;
  assign mil       = mil_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl at CLK_HZ=1000, TICK_HZ=100 (DIV=10).
module tb_stopwatch_ctrl;

  logic       mclk, reset, b_start, b_lap, b_clear;
  logic       run, lap_pulse, overflow;
  logic [7:0] min, sec, mil;
  int         n_checks, n_errors, cnt;

  stopwatch_ctrl #(
    .CLK_HZ(1000), .TICK_HZ(100), .DEBOUNCE_CYCLES(5)
  ) dut (
    .mclk(mclk), .reset(reset), .b_start(b_start), .b_lap(b_lap),
    .b_clear(b_clear), .run(run), .lap_pulse(lap_pulse), .min(min),
    .sec(sec), .mil(mil), .overflow(overflow)
  );

  initial begin
    mclk = 1'b0;
    forever #5 mclk = ~mclk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge mclk);
  endtask

  // One-cycle press of any combination of buttons, started on a falling edge.
  task automatic tap(input logic s, input logic l, input logic c);
    b_start = s;
    b_lap   = l;
    b_clear = c;
    @(negedge mclk);
    b_start = 1'b0;
    b_lap   = 1'b0;
    b_clear = 1'b0;
  endtask

  task automatic count_lap(input int n, output int c);
    c = 0;
    repeat (n) begin
      @(negedge mclk);
      if (lap_pulse) c++;
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b1;
    b_start  = 1'b0;
    b_lap    = 1'b0;
    b_clear  = 1'b0;
    cyc(3);
    check("rst_run", 32'(run), 0);
    check("rst_lap", 32'(lap_pulse), 0);
    check("rst_min", 32'(min), 0);
    check("rst_sec", 32'(sec), 0);
    check("rst_mil", 32'(mil), 0);
    check("rst_ovf", 32'(overflow), 0);
    reset = 1'b0;

`ifdef STOPWATCH_DEBOUNCE_EN
    cyc(12);
    b_start = 1'b1;
    cyc(3);
    b_start = 1'b0;
    cyc(20);
    check("glitch_run", 32'(run), 0);
    check("glitch_mil", 32'(mil), 0);
    b_start = 1'b1;
    cyc(12);
    b_start = 1'b0;
    cyc(5);
    check("held_run", 32'(run), 1);
`else
    cyc(5);
    // Start: run rises exactly three edges after the press is sampled.
    tap(1'b1, 1'b0, 1'b0);
    cyc(2);
    check("start_lat", 32'(run), 0);
    cyc(1);
    check("start_run", 32'(run), 1);
    check("start_mil", 32'(mil), 0);
    cyc(990);
    check("mil_99", 32'(mil), 99);
    check("sec_0", 32'(sec), 0);
    cyc(9);
    check("mil_99_hold", 32'(mil), 99);
    cyc(1);
    check("carry_sec", 32'(sec), 1);
    check("carry_mil", 32'(mil), 0);

    // Pause, lap while paused, then start+clear together.
    tap(1'b1, 1'b0, 1'b0);
    cyc(3);
    check("pause_run", 32'(run), 0);
    tap(1'b0, 1'b1, 1'b0);
    count_lap(6, cnt);
    check("lap_paused", 32'(cnt), 0);
    tap(1'b1, 1'b0, 1'b1);
    cyc(3);
    check("clr_run", 32'(run), 0);
    check("clr_sec", 32'(sec), 0);
    check("clr_mil", 32'(mil), 0);
    check("clr_min", 32'(min), 0);

    // Restart, pause at 00:00.37 with prescaler 7, resume.
    tap(1'b1, 1'b0, 1'b0);
    cyc(3);
    check("restart_run", 32'(run), 1);
    cyc(370);
    check("mil_37", 32'(mil), 37);
    cyc(3);
    tap(1'b1, 1'b0, 1'b0);
    cyc(3);
    check("pause2_run", 32'(run), 0);
    check("pause2_mil", 32'(mil), 37);
    cyc(500);
    check("held_mil", 32'(mil), 37);
    check("held_sec", 32'(sec), 0);
    check("held_run", 32'(run), 0);
    tap(1'b1, 1'b0, 1'b0);
    cyc(2);
    check("resume_lat", 32'(run), 0);
    cyc(1);
    check("resume_run", 32'(run), 1);
    check("resume_mil", 32'(mil), 37);
    cyc(2);
    check("resume_no_tick", 32'(mil), 37);
    cyc(1);
    check("resume_tick", 32'(mil), 38);

    // Lap while running, then clear while running.
    tap(1'b0, 1'b1, 1'b0);
    cyc(2);
    check("lap_early", 32'(lap_pulse), 0);
    cyc(1);
    check("lap_pulse", 32'(lap_pulse), 1);
    cyc(1);
    check("lap_one_cycle", 32'(lap_pulse), 0);
    check("lap_run", 32'(run), 1);
    tap(1'b0, 1'b0, 1'b1);
    cyc(4);
    check("clr_run_ignored", 32'(run), 1);
    check("clr_run_mil", 32'(mil), 39);

    // Start and lap together: pause wins, no lap strobe. Prescaler held at 4.
    tap(1'b1, 1'b1, 1'b0);
    count_lap(4, cnt);
    check("startlap_nolap", 32'(cnt), 0);
    check("startlap_run", 32'(run), 0);
    check("startlap_mil", 32'(mil), 39);

    // Preload 59:59.99 while paused, resume and wrap.
    force dut.min_q = 8'd59;
    force dut.sec_q = 8'd59;
    force dut.mil_q = 8'd99;
    cyc(1);
    release dut.min_q;
    release dut.sec_q;
    release dut.mil_q;
    cyc(1);
    check("pre_min", 32'(min), 59);
    check("pre_sec", 32'(sec), 59);
    check("pre_mil", 32'(mil), 99);
    tap(1'b1, 1'b0, 1'b0);
    cyc(3);
    check("wrap_run", 32'(run), 1);
    cyc(5);
    check("wrap_pre_mil", 32'(mil), 99);
    check("wrap_pre_ovf", 32'(overflow), 0);
    cyc(1);
    check("wrap_min", 32'(min), 0);
    check("wrap_sec", 32'(sec), 0);
    check("wrap_mil", 32'(mil), 0);
    check("wrap_ovf", 32'(overflow), 1);
    cyc(1);
    check("wrap_ovf_1cyc", 32'(overflow), 0);

    // Count to 00:03.41 then reset asynchronously between clock edges.
    cyc(3409);
    check("t341_sec", 32'(sec), 3);
    check("t341_mil", 32'(mil), 41);
    #2;
    reset   = 1'b1;
    b_start = 1'b1;
    #1;
    check("arst_run", 32'(run), 0);
    check("arst_sec", 32'(sec), 0);
    check("arst_mil", 32'(mil), 0);
    @(negedge mclk);
    cyc(2);
    reset = 1'b0;
    cyc(10);
    check("held_thru_rst", 32'(run), 0);
    b_start = 1'b0;
    cyc(3);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
